// File: rtl/kara_pkg.sv
// kara_pkg: state encoding, default width and latency helper for kara_mul_seq
package kara_pkg;
  localparam int KARA_W_DEF = 128;
  typedef enum logic [2:0] {IDLE, LOAD, PP_HH, PP_LL, PP_MID, COMBINE, DONE} state_t;
  function automatic int kara_lat(input int w);
    return 3 * (w / 2 + 2) + 2;
  endfunction
endpackage

// File: rtl/kara_shift_mul.sv
// kara_shift_mul: unsigned MxM radix-2 shift-add multiplier, valid pulses M cycles after go
module kara_shift_mul #(
  parameter int M = 65
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [2*M-1:0] p,
  output logic           valid
);
  localparam int CW = $clog2(M);
  logic [2*M-1:0] a_q, acc_q;
  logic [M-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic           valid_q;
  // go folds in the bit-0 partial product so the remaining M-1 steps finish exactly M cycles after go
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (go) begin
        acc_q <= b[0] ? {{M{1'b0}}, a} : '0;
        a_q   <= {{(M-1){1'b0}}, a, 1'b0};
        b_q   <= b >> 1;
        cnt_q <= CW'(M - 1);
      end else if (cnt_q != '0) begin
        acc_q   <= acc_q + (b_q[0] ? a_q : '0);
        a_q     <= a_q << 1;
        b_q     <= b_q >> 1;
        cnt_q   <= cnt_q - CW'(1);
        valid_q <= cnt_q == CW'(1);
      end
    end
  assign p     = acc_q;
  assign valid = valid_q;
endmodule

// File: rtl/kara_mul_seq.sv
// kara_mul_seq: sequential Karatsuba WxW multiplier; KARA_SIGNED_EN adds two's-complement mode
module kara_mul_seq
  import kara_pkg::*;
#(
  parameter int W = KARA_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
`ifdef KARA_SIGNED_EN
  input  logic           signed_mode,
`endif
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] z
);
  localparam int H = W / 2;
  localparam int M = H + 1;
  state_t         state_q;
  logic [W-1:0]   x_q, y_q;
  logic [M-1:0]   sx_q, sy_q;
  logic [2*H-1:0] phh_q, pll_q;
  logic [2*M-1:0] pm_q;
  logic [2*W-1:0] z_q;
  logic           sm_q, sign_q, go_q, busy_q, done_q;
  logic           sm;
  logic [M-1:0]   mul_a, mul_b;
  logic [2*M-1:0] mul_p;
  logic           mul_v;
  logic [W-1:0]   mag_x, mag_y;
  logic [2*H+1:0] mid;
  logic [2*W-1:0] zsum;
`ifdef KARA_SIGNED_EN
  assign sm = signed_mode;
`else
  assign sm = 1'b0;
`endif
  // operand select for the shared sub-multiplier, magnitudes, and Karatsuba recombination (mod 2^2W)
  always_comb begin
    mul_a = state_q == PP_HH ? {1'b0, x_q[W-1:H]} : state_q == PP_LL ? {1'b0, x_q[H-1:0]} : sx_q;
    mul_b = state_q == PP_HH ? {1'b0, y_q[W-1:H]} : state_q == PP_LL ? {1'b0, y_q[H-1:0]} : sy_q;
    mag_x = (sm_q && x_q[W-1]) ? -x_q : x_q;
    mag_y = (sm_q && y_q[W-1]) ? -y_q : y_q;
    mid   = pm_q - {2'b00, phh_q} - {2'b00, pll_q};
    zsum  = {phh_q, {W{1'b0}}} + ({{(W-2){1'b0}}, mid} << H) + {{W{1'b0}}, pll_q};
  end
  kara_shift_mul #(.M(M)) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .go   (go_q),
    .a    (mul_a),
    .b    (mul_b),
    .p    (mul_p),
    .valid(mul_v)
  );
  // control FSM: capture, split, three shared partial products, combine, one-cycle done
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      phh_q   <= '0;
      pll_q   <= '0;
      pm_q    <= '0;
      z_q     <= '0;
      sm_q    <= 1'b0;
      sign_q  <= 1'b0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      go_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          busy_q  <= start;
          state_q <= start ? LOAD : IDLE;
          if (start) begin
            x_q  <= x;
            y_q  <= y;
            sm_q <= sm;
          end
        end
        LOAD: begin
          x_q     <= mag_x;
          y_q     <= mag_y;
          sign_q  <= sm_q & (x_q[W-1] ^ y_q[W-1]);
          sx_q    <= {1'b0, mag_x[W-1:H]} + {1'b0, mag_x[H-1:0]};
          sy_q    <= {1'b0, mag_y[W-1:H]} + {1'b0, mag_y[H-1:0]};
          go_q    <= 1'b1;
          state_q <= PP_HH;
        end
        PP_HH: if (mul_v) begin
          phh_q   <= mul_p[2*H-1:0];
          go_q    <= 1'b1;
          state_q <= PP_LL;
        end
        PP_LL: if (mul_v) begin
          pll_q   <= mul_p[2*H-1:0];
          go_q    <= 1'b1;
          state_q <= PP_MID;
        end
        PP_MID: if (mul_v) begin
          pm_q    <= mul_p;
          state_q <= COMBINE;
        end
        COMBINE: begin
          z_q     <= sign_q ? -zsum : zsum;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;
endmodule
